// File: rtl/key_loader.sv
// key_loader: stores a 128-bit key as four words and streams it MSB-first, one byte per cycle
module key_loader #(
    parameter bit CLR_ON_DONE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] key_word,
    input  logic [1:0]  key_idx,
    input  logic        key_wr,
    input  logic        start,
    input  logic        abort,
    output logic        ready,
    output logic [7:0]  key_byte,
    output logic        key_sel,
    output logic        key_done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] key_q [4];
    logic [31:0] key_d [4];
    logic [7:0]  byte_q, byte_d;
    logic        err_q, err_d;
    logic [31:0] word_sel;

    assign ready    = state_q == IDLE;
    assign key_sel  = state_q == STREAM;
    assign key_done = state_q == DONE;
    assign key_byte = byte_q;
    assign err      = err_q;

    // Next state, key storage and the byte that will be visible in the next cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        key_d   = key_q;
        err_d   = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            mask_d  = '0;
            key_d   = '{default: '0};
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (key_wr) begin
                        key_d[key_idx]  = key_word;
                        mask_d[key_idx] = 1'b1;
                    end else if (start) begin
                        if (&mask_q) begin
                            state_d = STREAM;
                            cnt_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                STREAM: begin
                    err_d = key_wr;
                    cnt_d = cnt_q + 4'd1;
                    state_d = (cnt_q == 4'd15) ? DONE : STREAM;
                end
                DONE: begin
                    err_d   = key_wr;
                    state_d = IDLE;
                    if (CLR_ON_DONE) begin
                        mask_d = '0;
                        key_d  = '{default: '0};
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        word_sel = key_q[cnt_d[3:2]];
        byte_d   = (state_d == STREAM) ? word_sel[{~cnt_d[1:0], 3'b000} +: 8] : 8'h00;
    end

    // State, key and output registers; reset clears everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            key_q   <= '{default: '0};
            byte_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            key_q   <= key_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 SHALL have parameter CLR_ON_DONE, default 1; when 1, the key words and the valid mask are zeroized on completion of a stream.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port key_word, input, 32, key word write data.
REQ-005 SHALL have port key_idx, input, 2, word slot to write (0 = most significant key word).
REQ-006 SHALL have port key_wr, input, 1, write strobe, valid for one cycle.
REQ-007 SHALL have port start, input, 1, request to stream the stored key.
REQ-008 SHALL have port abort, input, 1, synchronous cancel.
REQ-009 SHALL have port ready, output, 1, high when in IDLE.
REQ-010 SHALL have port key_byte, output, 8, serial key byte feeding the key-expansion byte input.
REQ-011 SHALL have port key_sel, output, 1, selects the external key byte at key expansion; high exactly while key_byte is valid.
REQ-012 SHALL have port key_done, output, 1, one-cycle pulse after the last byte.
REQ-013 SHALL have port err, output, 1, one-cycle pulse on a protocol violation.

Function
REQ-014 SHALL implement a state machine with states IDLE, STREAM and DONE, plus a 4-bit valid mask, four 32-bit key registers and a 4-bit byte counter.
REQ-015 SHALL, in IDLE with key_wr=1, store key_word into slot key_idx and set mask[key_idx]; rewriting a slot overwrites it.
REQ-016 SHALL, in IDLE with start=1 and mask=4'hF, enter STREAM at the next edge with the byte counter cleared to 0.
REQ-017 SHALL, in IDLE with start=1 and mask not equal to 4'hF, stay in IDLE and pulse err in the next cycle.
REQ-018 SHALL give key_wr priority when key_wr and start are both asserted in the same IDLE cycle: the write is performed, start is ignored and no err is raised.
REQ-019 SHALL, in STREAM, drive key_byte from a register and key_sel=1 for exactly 16 consecutive cycles.
REQ-020 SHALL stream bytes in the order word0[31:24], word0[23:16], ... , word3[7:0]; byte n = word[n/4] bits [31-8*(n%4) -: 8].
REQ-021 SHALL make the first byte visible in the cycle immediately after the edge that accepted start (latency 1).
REQ-022 SHALL hold key_byte=8'h00 and key_sel=0 outside STREAM.
REQ-023 SHALL, after byte 15 (counter wraps 15 to 0), enter DONE for one cycle with key_done=1, then return to IDLE.
REQ-024 SHALL, in DONE with CLR_ON_DONE=1, clear all key registers and the mask; with CLR_ON_DONE=0, retain both so start alone replays the key.
REQ-025 SHALL ignore key_wr in STREAM and DONE, leaving key and mask unchanged, and pulse err in the next cycle.
REQ-026 SHALL ignore start outside IDLE with no err.
REQ-027 SHALL, on abort=1 in any state, go to IDLE at the next edge with key_sel=0, no key_done, and key registers and mask cleared regardless of CLR_ON_DONE; abort has priority over key_wr and start.
REQ-028 SHALL make ready=1 only in IDLE.

Reset
REQ-029 SHALL, on rst=1 and without waiting for clk, force: state IDLE; mask 0; key registers 0; counter 0; key_byte 8'h00; key_sel 0; key_done 0; err 0; ready 1.
REQ-030 SHALL, if rst is asserted mid-STREAM, drop key_sel immediately and produce no key_done after release.

Verification
REQ-031 Load the FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c in slots 0..3, then start -> next 16 cycles key_sel=1, bytes 2b,7e,15,16,...,4f,3c; then key_done=1 for one cycle; then ready=1 and mask=0.
REQ-032 Write slots 0..2 only, then start -> state stays IDLE, err=1 for one cycle, key_sel stays 0.
REQ-033 With CLR_ON_DONE=0, stream the key, then start again with no writes -> the identical 16-byte sequence is repeated.
REQ-034 Assert abort at byte 7 of a stream -> key_sel=0 next cycle, no key_done, mask=0, ready=1.
REQ-035 Assert rst asynchronously at byte 3 -> all outputs take reset values before the next clk edge; no key_done after release.
REQ-036 Assert key_wr during STREAM -> err pulses, the streamed bytes are unchanged, and the stored word is unchanged afterwards (checked with CLR_ON_DONE=0).
